serial_paralelo_rx_param: RTL and testbench

SERIAL_PARALELO_RX_PARAM -- requirements
Module: serial_paralelo_rx_param

---
 rtl/serial_rx_pkg.sv | 23 ++
 rtl/sp_word_assembler.sv | 53 +++++
 rtl/serial_paralelo_rx_param.sv | 162 ++++++++++++++++
 tb/tb_serial_paralelo_rx_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_rx_pkg
//  Purpose  : Shared definitions for the serial-to-parallel receiver.
//             Contains the receiver state encoding and the default comma symbol.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_rx_pkg;

   // The receiver FSM state encoding. Value 2'd3 is not used; the FSM
   // recovers from it by going to HUNT.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } rx_state_t;

   // Default alignment/idle symbol. This is a K28.5-style pattern.
   localparam logic [7:0] C_DEFAULT_COMMA = 8'hBC;

endpackage
`default_nettype wire

// File: rtl/sp_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : sp_word_assembler
//  Purpose  : Shifts in one serial bit per clock (MSB first). Presents the
//             candidate word, which is the stored bits followed by the bit on
//             data_in now. Also tracks the bit position inside a word.
//  Ports    : clk       - bit clock
//             rst       - synchronous active-high reset
//             data_in   - serial bit
//             realign   - restarts the word phase (bit position 0 next cycle)
//             candidate - {stored bits, data_in}, WIDTH bits
//             boundary  - high while the current bit completes a word
//  Revision : 1.0 - initial release
// ============================================================================
module sp_word_assembler #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_in,
   input  logic             realign,
   output logic [WIDTH-1:0] candidate,
   output logic             boundary
);

   localparam int                 C_CNT_W = $clog2(WIDTH);
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

   // Only the WIDTH-1 youngest bits ever reach the candidate word. The next
   // shift would push the oldest bit of a full WIDTH-bit register out, so
   // that bit is never stored.
   logic [WIDTH-2:0]   r_sr;
   logic [C_CNT_W-1:0] r_bit_cnt;

   assign candidate = {r_sr, data_in};
   assign boundary  = (r_bit_cnt == C_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr      <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_sr <= candidate[WIDTH-2:0];
         if (realign || (r_bit_cnt == C_LAST)) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_paralelo_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : serial_paralelo_rx_param
//  Purpose  : Comma-aligned serial-to-parallel receiver.
//             - HUNT   : searches for COMMA at every bit position.
//             - ALIGN  : needs LOCK_COUNT aligned commas in a row to lock.
//             - ACTIVE : outputs each non-comma word with a one-cycle strobe.
//               Drops the lock after MAX_GAP non-comma words in a row.
//  Ports    : clk_32f   - serial bit clock
//             reset     - synchronous active-high reset
//             data_in   - serial bit, MSB first
//             sp_out    - last received data word
//             valid_out - one-cycle strobe, sp_out holds a new word
//             active    - receiver locked (registered)
//             comma_det - one-cycle strobe, aligned comma in ALIGN/ACTIVE
//             state_out - current FSM state
//  Revision : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx_param
   import serial_rx_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(C_DEFAULT_COMMA),
   parameter int               LOCK_COUNT = 4,
   parameter int               MAX_GAP    = 16
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] sp_out,
   output logic             valid_out,
   output logic             active,
   output logic             comma_det,
   output logic [1:0]       state_out
);

   localparam int               C_CNT_W   = $clog2(LOCK_COUNT + 1);
   localparam int               C_GAP_W   = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);
   localparam logic [C_CNT_W-1:0] C_LOCK    = C_CNT_W'(LOCK_COUNT);
   localparam logic [C_GAP_W-1:0] C_GAP_MAX = C_GAP_W'(MAX_GAP);

   rx_state_t          r_state;
   logic [C_CNT_W-1:0] r_comma_cnt;
   logic [C_GAP_W-1:0] r_gap_cnt;

   rx_state_t          w_state_nxt;
   logic [C_CNT_W-1:0] w_comma_nxt;
   logic [C_GAP_W-1:0] w_gap_nxt;
   logic [WIDTH-1:0]   w_sp_nxt;
   logic               w_valid_nxt;
   logic               w_cdet_nxt;
   logic               w_realign;
   logic [WIDTH-1:0]   w_candidate;
   logic               w_boundary;
   logic               w_is_comma;
   logic [C_CNT_W-1:0] w_comma_inc;
   logic [C_GAP_W-1:0] w_gap_inc;

   sp_word_assembler #(
      .WIDTH (WIDTH)
   ) u_assembler (
      .clk       (clk_32f),
      .rst       (reset),
      .data_in   (data_in),
      .realign   (w_realign),
      .candidate (w_candidate),
      .boundary  (w_boundary)
   );

   assign w_is_comma  = (w_candidate == COMMA);
   // Both counters saturate at their maxima and never wrap.
   assign w_comma_inc = (r_comma_cnt == C_LOCK)    ? r_comma_cnt : r_comma_cnt + C_CNT_W'(1);
   assign w_gap_inc   = (r_gap_cnt   == C_GAP_MAX) ? r_gap_cnt   : r_gap_cnt   + C_GAP_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_comma_nxt = r_comma_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_sp_nxt    = sp_out;
      w_valid_nxt = 1'b0;
      w_cdet_nxt  = 1'b0;
      w_realign   = 1'b0;

      case (r_state)
         HUNT: begin
            // Bit-level search. A match defines the new word phase.
            if (w_is_comma) begin
               w_realign   = 1'b1;
               w_comma_nxt = C_CNT_W'(1);
               w_gap_nxt   = '0;
               w_state_nxt = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
            end
         end
         ALIGN: begin
            if (w_boundary) begin
               if (w_is_comma) begin
                  w_comma_nxt = w_comma_inc;
                  w_cdet_nxt  = 1'b1;
                  if (w_comma_inc == C_LOCK) begin
                     w_state_nxt = ACTIVE;
                     w_gap_nxt   = '0;
                  end
               end else begin
                  w_state_nxt = HUNT;
                  w_comma_nxt = '0;
               end
            end
         end
         ACTIVE: begin
            if (w_boundary) begin
               if (w_is_comma) begin
                  w_cdet_nxt = 1'b1;
                  w_gap_nxt  = '0;
               end else begin
                  w_sp_nxt    = w_candidate;
                  w_valid_nxt = 1'b1;
                  if (MAX_GAP > 0) begin
                     w_gap_nxt = w_gap_inc;
                     // The word that hits the limit is still delivered.
                     if (w_gap_inc == C_GAP_MAX) begin
                        w_state_nxt = HUNT;
                        w_comma_nxt = '0;
                        w_gap_nxt   = '0;
                     end
                  end
               end
            end
         end
         default: begin
            w_state_nxt = HUNT;
            w_comma_nxt = '0;
            w_gap_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_state     <= HUNT;
         r_comma_cnt <= '0;
         r_gap_cnt   <= '0;
         sp_out      <= '0;
         valid_out   <= 1'b0;
         comma_det   <= 1'b0;
         active      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_comma_cnt <= w_comma_nxt;
         r_gap_cnt   <= w_gap_nxt;
         sp_out      <= w_sp_nxt;
         valid_out   <= w_valid_nxt;
         comma_det   <= w_cdet_nxt;
         // Registered decode of the state being entered. The flop output
         // therefore follows the state register with no path from data_in.
         active      <= (w_state_nxt == ACTIVE);
      end
   end

   assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_paralelo_rx_param
//  Purpose  : Self-checking bench. Drives two receivers (MAX_GAP=16 and
//             MAX_GAP=4) from the same bit stream. Every cycle, the bench
//             compares their outputs against a word-level model built from
//             the receiver rules.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_rx_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] sp_a, sp_b;
   logic       valid_a, valid_b, active_a, active_b, cdet_a, cdet_b;
   logic [1:0] st_a, st_b;

   always #5 clk = ~clk;

   serial_paralelo_rx_param dut_a (
      .clk_32f(clk), .reset(reset), .data_in(data_in), .sp_out(sp_a),
      .valid_out(valid_a), .active(active_a), .comma_det(cdet_a), .state_out(st_a)
   );

   serial_paralelo_rx_param #(.MAX_GAP(4)) dut_b (
      .clk_32f(clk), .reset(reset), .data_in(data_in), .sp_out(sp_b),
      .valid_out(valid_b), .active(active_b), .comma_det(cdet_b), .state_out(st_b)
   );

   int tests = 0;
   int fails = 0;
   int vcnt_a, vcnt_b;

   // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ---------
   // mode: 0 searching, 1 counting commas, 2 locked
   int         m_mode [2];
   int         m_since[2];   // bits consumed since the comma that set the phase
   int         m_commas[2];
   int         m_gaps [2];
   logic [7:0] m_sp   [2];
   logic       m_valid[2];
   logic       m_cdet [2];
   logic [7:0] hist;

   function automatic int gap_of(input int m);
      return (m == 0) ? 16 : 4;
   endfunction

   task automatic model_step(input logic r, input logic d);
      logic [7:0] word;
      bit         bnd;
      word = {hist[6:0], d};
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 1'b0;
         m_cdet[m]  = 1'b0;
         if (r) begin
            m_mode[m] = 0; m_since[m] = 0; m_commas[m] = 0; m_gaps[m] = 0; m_sp[m] = 8'h00;
         end else begin
            bnd = ((m_since[m] % 8) == 7);
            m_since[m]++;
            if (m_mode[m] == 0) begin
               if (word == 8'hBC) begin
                  m_mode[m] = 1; m_commas[m] = 1; m_since[m] = 0; m_gaps[m] = 0;
               end
            end else if (bnd) begin
               if (m_mode[m] == 1) begin
                  if (word == 8'hBC) begin
                     m_commas[m]++;
                     m_cdet[m] = 1'b1;
                     if (m_commas[m] >= 4) begin m_mode[m] = 2; m_gaps[m] = 0; end
                  end else begin
                     m_mode[m] = 0; m_commas[m] = 0;
                  end
               end else begin
                  if (word == 8'hBC) begin
                     m_cdet[m] = 1'b1; m_gaps[m] = 0;
                  end else begin
                     m_sp[m] = word; m_valid[m] = 1'b1; m_gaps[m]++;
                     if (m_gaps[m] >= gap_of(m)) begin
                        m_mode[m] = 0; m_gaps[m] = 0; m_commas[m] = 0;
                     end
                  end
               end
            end
         end
      end
      hist = r ? 8'h00 : word;
   endtask

   // ---------------- checking helpers ---------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("a_sp",     32'(sp_a),     32'(m_sp[0]));
      check("a_valid",  32'(valid_a),  32'(m_valid[0]));
      check("a_active", 32'(active_a), 32'(m_mode[0] == 2));
      check("a_cdet",   32'(cdet_a),   32'(m_cdet[0]));
      check("a_state",  32'(st_a),     32'(m_mode[0]));
      check("b_sp",     32'(sp_b),     32'(m_sp[1]));
      check("b_valid",  32'(valid_b),  32'(m_valid[1]));
      check("b_active", 32'(active_b), 32'(m_mode[1] == 2));
      check("b_cdet",   32'(cdet_b),   32'(m_cdet[1]));
      check("b_state",  32'(st_b),     32'(m_mode[1]));
   endtask

   task automatic tick(input logic r, input logic d);
      reset   = r;
      data_in = d;
      @(posedge clk);
      model_step(r, d);
      #1;
      compare_all();
      if (valid_a) vcnt_a++;
      if (valid_b) vcnt_b++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) tick(1'b0, b[i]);
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
   endtask

   // ---------------- directed vector table ----------------------------------
   typedef struct packed {
      logic [3:0]  njunk;
      logic [2:0]  junk;
      logic [3:0]  nbytes;
      logic [95:0] bytes;      // first byte in the top 8 bits
      logic [7:0]  valids_a;
      logic [7:0]  valids_b;
      logic [7:0]  last_a;
      logic [7:0]  last_b;
      logic        act_a;
      logic        act_b;
      logic [1:0]  st_a;
      logic [1:0]  st_b;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mkv(input int nj, input logic [2:0] j, input int nb,
                                input logic [95:0] b, input int va, input int vb,
                                input logic [7:0] la, input logic [7:0] lb,
                                input logic aa, input logic ab,
                                input logic [1:0] sa, input logic [1:0] sb);
      vec_t v;
      v.njunk = 4'(nj); v.junk = j; v.nbytes = 4'(nb); v.bytes = b;
      v.valids_a = 8'(va); v.valids_b = 8'(vb); v.last_a = la; v.last_b = lb;
      v.act_a = aa; v.act_b = ab; v.st_a = sa; v.st_b = sb;
      return v;
   endfunction

   int         r_sel, p_comma, nj;
   logic [7:0] bc;

   initial begin
      bc = 8'hBC;
      // Vectors: F2,15 prelude; junk offset; broken run; gap drop at 4; comma within data; gap reset
      vecs[0] = mkv(0, 3'b000,  8, 96'hF215BCBC_BCBCDD45_00000000, 2, 2, 8'h45, 8'h45, 1'b1, 1'b1, 2'd2, 2'd2);
      vecs[1] = mkv(3, 3'b101,  5, 96'hBCBCBCBC_AA000000_00000000, 1, 1, 8'hAA, 8'hAA, 1'b1, 1'b1, 2'd2, 2'd2);
      vecs[2] = mkv(0, 3'b000,  8, 96'hBCBC55BC_BCBCBC13_00000000, 1, 1, 8'h13, 8'h13, 1'b1, 1'b1, 2'd2, 2'd2);
      vecs[3] = mkv(0, 3'b000,  8, 96'hBCBCBCBC_DD45AA13_00000000, 4, 4, 8'h13, 8'h13, 1'b1, 1'b0, 2'd2, 2'd0);
      vecs[4] = mkv(0, 3'b000,  7, 96'hBCBCBCBC_DDBC4500_00000000, 2, 2, 8'h45, 8'h45, 1'b1, 1'b1, 2'd2, 2'd2);
      vecs[5] = mkv(0, 3'b000, 10, 96'hBCBCBCBC_DD45AABC_13550000, 5, 5, 8'h55, 8'h55, 1'b1, 1'b1, 2'd2, 2'd2);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         vcnt_a = 0;
         vcnt_b = 0;
         for (int j = 0; j < int'(vecs[v].njunk); j++) tick(1'b0, vecs[v].junk[int'(vecs[v].njunk) - 1 - j]);
         for (int k = 0; k < int'(vecs[v].nbytes); k++) send_byte(vecs[v].bytes[95 - 8*k -: 8]);
         check("vec_valids_a", 32'(vcnt_a),   32'(vecs[v].valids_a));
         check("vec_valids_b", 32'(vcnt_b),   32'(vecs[v].valids_b));
         check("vec_last_a",   32'(sp_a),     32'(vecs[v].last_a));
         check("vec_last_b",   32'(sp_b),     32'(vecs[v].last_b));
         check("vec_active_a", 32'(active_a), 32'(vecs[v].act_a));
         check("vec_active_b", 32'(active_b), 32'(vecs[v].act_b));
         check("vec_state_a",  32'(st_a),     32'(vecs[v].st_a));
         check("vec_state_b",  32'(st_b),     32'(vecs[v].st_b));
      end

      // Lock timing: active must rise exactly on the last bit of the 4th comma.
      do_reset();
      send_byte(8'hF2); send_byte(8'h15); send_byte(bc); send_byte(bc); send_byte(bc);
      for (int i = 7; i >= 1; i--) tick(1'b0, bc[i]);
      check("lock_early_active", 32'(active_a), 32'd0);
      tick(1'b0, bc[0]);
      check("lock_active", 32'(active_a), 32'd1);
      check("lock_cdet",   32'(cdet_a),   32'd1);
      check("lock_valid",  32'(valid_a),  32'd0);

      // A comma between data words pulses comma_det and holds sp_out.
      send_byte(8'hDD);
      check("dd_valid", 32'(valid_a), 32'd1);
      check("dd_sp",    32'(sp_a),    32'hDD);
      send_byte(bc);
      check("mid_cdet",  32'(cdet_a),  32'd1);
      check("mid_valid", 32'(valid_a), 32'd0);
      check("mid_sp",    32'(sp_a),    32'hDD);
      tick(1'b0, 1'b0);
      check("mid_cdet_drop", 32'(cdet_a), 32'd0);

      // Reset in the middle of a word while locked.
      do_reset();
      send_byte(bc); send_byte(bc); send_byte(bc); send_byte(bc);
      tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      check("rst_sp",     32'(sp_a),     32'd0);
      check("rst_valid",  32'(valid_a),  32'd0);
      check("rst_active", 32'(active_a), 32'd0);
      check("rst_cdet",   32'(cdet_a),   32'd0);
      check("rst_state",  32'(st_a),     32'd0);
      send_byte(bc); send_byte(bc); send_byte(bc);
      check("relock_3", 32'(active_a), 32'd0);
      send_byte(bc);
      check("relock_4", 32'(active_a), 32'd1);
      send_byte(8'h13);
      check("relock_sp", 32'(sp_a), 32'h13);

      // Random traffic. Commas are likely while unlocked and rare once locked,
      // so both the lock and the gap-drop paths are exercised.
      do_reset();
      for (int it = 0; it < 400; it++) begin
         r_sel   = int'($urandom_range(0, 15));
         p_comma = (m_mode[0] == 2) ? 3 : 10;
         if (r_sel < p_comma) begin
            send_byte(bc);
         end else if (r_sel == 15) begin
            if ($urandom_range(0, 3) == 0) begin
               tick(1'b1, 1'b0);
            end else begin
               nj = int'($urandom_range(1, 3));
               for (int j = 0; j < nj; j++) tick(1'b0, 1'($urandom));
            end
         end else begin
            send_byte(8'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
